ffss_mod_sub: RTL and testbench

Multi-cycle 256-bit modular subtractor, out = (a − b) mod P, for the finite-field arithmetic layer of the ECC scalar-multiplication datapath. It processes operands limb-serially (64-bit limbs) with a fixed, data-independent latency so the higher-level point-arithmetic controllers see constant timing. A start/done handshake lets the point-arithmetic sequencer issue operations and poll for completion.

---
 rtl/ffss_mod_sub.sv | 76 +++++++
 tb/tb_ffss_mod_sub.sv | 129 ++++++++++++
 2 files changed

// File: rtl/ffss_mod_sub.sv
// ffss_mod_sub: constant-latency limb-serial 256-bit modular subtractor, out = (a - b) mod P
module ffss_mod_sub #(
  parameter logic [255:0] P = 256'h7fffffffffffffffffffffffffffffffffffffffffffffffffffffffffffffed,
  parameter int LIMB = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [255:0] a,
  input  logic [255:0] b,
  output logic [255:0] out,
  output logic         done
);
  localparam int NLIMB = 256 / LIMB;
  localparam int IW = NLIMB > 1 ? $clog2(NLIMB) : 1;
  localparam logic [IW-1:0] LAST = IW'(NLIMB - 1);
  typedef enum logic [1:0] {IDLE, SUB, CORR, DONE} state_t;
  state_t state;
  logic [255:0] ra, rb, diff, sub_sh, add_sh;
  logic [IW-1:0] idx;
  logic borrow, carry, sub_bo, add_co;
  logic [LIMB-1:0] sub_d, add_s;
  // Limb arithmetic on the low limb; operands and diff shift right one limb per cycle
  always_comb begin
    {sub_bo, sub_d} = {1'b0, ra[LIMB-1:0]} - {1'b0, rb[LIMB-1:0]} - (LIMB+1)'(borrow);
    {add_co, add_s} = {1'b0, diff[LIMB-1:0]} + {1'b0, rb[LIMB-1:0]} + (LIMB+1)'(carry);
    sub_sh = 256'({sub_d, diff} >> LIMB);
    add_sh = 256'({add_s, diff} >> LIMB);
  end
  // Sequencer: capture, NLIMB subtract cycles, NLIMB correction cycles (P or 0 added), publish
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      ra     <= '0;
      rb     <= '0;
      diff   <= '0;
      idx    <= '0;
      borrow <= 1'b0;
      carry  <= 1'b0;
      out    <= '0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          ra     <= a;
          rb     <= b;
          diff   <= '0;
          idx    <= '0;
          borrow <= 1'b0;
          carry  <= 1'b0;
          done   <= 1'b0;
          state  <= SUB;
        end
        SUB: begin
          diff   <= sub_sh;
          ra     <= ra >> LIMB;
          borrow <= sub_bo;
          idx    <= idx == LAST ? '0 : idx + 1'b1;
          rb     <= idx == LAST ? (sub_bo ? P : '0) : rb >> LIMB;
          state  <= idx == LAST ? CORR : SUB;
        end
        CORR: begin
          diff  <= add_sh;
          rb    <= rb >> LIMB;
          carry <= add_co;
          idx   <= idx == LAST ? '0 : idx + 1'b1;
          if (idx == LAST) begin
            out   <= add_sh;
            done  <= 1'b1;
            state <= DONE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ffss_mod_sub.sv
// tb_ffss_mod_sub: randomized scoreboard bench for ffss_mod_sub
module tb_ffss_mod_sub;
  localparam logic [255:0] P = (256'd1 << 255) - 256'd19;
  localparam logic [255:0] K1 = 256'd45965849458578823337285628114947185621072782472466027602082789798859530730302;
  localparam logic [255:0] K2 = 256'd45965849458578823337785628114947185621072782472466027602082789798859530730301;
  typedef struct {logic [255:0] v; int cap;} exp_t;
  logic clk = 0, rst = 0, start = 0, done, done_q = 0;
  logic [255:0] a = '0, b = '0, out;
  int cyc = 0, compared = 0, mismatched = 0;
  exp_t q[$];

  ffss_mod_sub dut (.clk(clk), .rst(rst), .start(start), .a(a), .b(b), .out(out), .done(done));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [255:0] ref_sub(input logic [255:0] x, input logic [255:0] y);
    return x >= y ? x - y : x - y + P;
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [255:0] rnd_field();
    logic [255:0] r;
    r = rnd256();
    r[255] = 1'b0;
    return r >= P ? r - P : r;
  endfunction

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Monitor: every rising done must match the oldest outstanding operation
  always @(negedge clk) begin
    if (rst && done && !done_q) begin
      if (q.size() == 0) chk("unexpected_done", 256'd1, 256'd0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("result", out, e.v);
        chk("latency", 256'(cyc - e.cap), 256'd8);
      end
    end
    done_q <= done;
  end

  task automatic issue(input logic [255:0] x, input logic [255:0] y);
    @(negedge clk);
    a = x;
    b = y;
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
    q.push_back('{ref_sub(x, y), cyc});
    chk("done_drop", {255'd0, done}, 256'd0);
  endtask

  task automatic wait_done();
    int n = 0;
    while (q.size() != 0 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (q.size() != 0) begin
      chk("timeout", 256'd1, 256'd0);
      q.delete();
    end
  endtask

  task automatic op(input logic [255:0] x, input logic [255:0] y);
    issue(x, y);
    wait_done();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_out", out, 256'd0);
    chk("reset_done", {255'd0, done}, 256'd0);
    rst = 1;
    op(256'd5, 256'd3);
    op(256'd3, 256'd5);
    op(K1, K1);
    op(256'd0, P - 256'd1);
    op(K1, K2);
    // Start pulses and operand changes mid-operation must not disturb it
    issue(rnd_field(), rnd_field());
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k >= 2 && k <= 6) begin
        a = rnd256();
        b = rnd256();
        start = 1'($urandom);
      end else start = 0;
    end
    wait_done();
    repeat (6) @(negedge clk);
    chk("done_held", {255'd0, done}, 256'd1);
    chk("out_held", out, ref_sub(dut.ra == '0 ? out : out, 256'd0));
    for (int i = 0; i < 16; i++) op(rnd_field(), rnd_field());
    for (int i = 0; i < 4; i++) op(rnd256(), rnd256());
    // Asynchronous reset partway through an operation
    issue(rnd_field(), rnd_field());
    repeat (3) @(posedge clk);
    #3;
    rst = 0;
    #1;
    chk("async_rst_out", out, 256'd0);
    chk("async_rst_done", {255'd0, done}, 256'd0);
    q.delete();
    @(negedge clk);
    rst = 1;
    op(256'd5, 256'd3);
    op(K2, K1);
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
